// File: rtl/regfile_host_port.sv
// Host-side command front end for the 16-entry register file: buffers read/write
// commands in an in-order FIFO, executes them against the file and returns one response each.
module regfile_host_port #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [AW-1:0]            cmd_addr,
    input  logic [DW-1:0]            cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_write,
    output logic                     rsp_err,
    output logic                     rf_write,
    output logic [AW-1:0]            rf_wrAddr,
    output logic [DW-1:0]            rf_wrData,
    output logic [AW-1:0]            rf_rdAddr,
    input  logic [DW-1:0]            rf_rdData,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               err_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    // One extra bit so NUM_REGS == 2**AW still compares correctly.
    localparam logic [AW:0] REG_LIMIT = (AW + 1)'(NUM_REGS);

    logic          fifoWrite [DEPTH];
    logic [AW-1:0] fifoAddr  [DEPTH];
    logic [DW-1:0] fifoData  [DEPTH];

    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;

    logic          push;
    logic          exec;
    logic          headWrite;
    logic [AW-1:0] headAddr;
    logic [DW-1:0] headData;
    logic          headErr;

    assign cmd_ready = (count != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;

    assign headWrite = fifoWrite[rdPtr];
    assign headAddr  = fifoAddr[rdPtr];
    assign headData  = fifoData[rdPtr];
    assign headErr   = ({1'b0, headAddr} >= REG_LIMIT);

    // The head may execute only when the response slot is free or being drained this cycle.
    assign exec = (count != '0) && (!rsp_valid || rsp_ready);

    assign rf_rdAddr  = headAddr;
    assign rf_wrAddr  = headAddr;
    assign rf_wrData  = headData;
    assign rf_write   = exec && headWrite && !headErr;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifoWrite[wrPtr] <= cmd_write;
            fifoAddr[wrPtr]  <= cmd_addr;
            fifoData[wrPtr]  <= cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (exec) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !exec) begin
                count <= count + 1'b1;
            end else if (!push && exec) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (exec) begin
            rsp_valid <= 1'b1;
            rsp_write <= headWrite;
            rsp_err   <= headErr;
            rsp_data  <= (!headWrite && !headErr) ? rf_rdData : '0;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (exec && headErr && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
